// File: rtl/trip_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : trip_stats_pkg                                              |
// | Brief  : Shared constants, types and helpers for the trip computer:  |
// |          FSM state encodings, ASCII digit base, BCD digit width and  |
// |          a saturating two-digit BCD increment.                       |
// | Ports  : none (package)                                              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package trip_stats_pkg;

  localparam int BCD_W = 4;
  localparam logic [6:0] ASCII_ZERO = 7'h30;

  // Run-control FSM encodings (2 bits)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  localparam bcd2_t BCD2_ZERO = '{tens: 4'd0, ones: 4'd0};

  // Two-digit BCD +1 that sticks at 99.
  function automatic bcd2_t bcd2_inc_sat(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones != 4'd9) begin
      r.ones = v.ones + 4'd1;
    end else if (v.tens != 4'd9) begin
      r.tens = v.tens + 4'd1;
      r.ones = 4'd0;
    end
    return r;
  endfunction

  function automatic logic [6:0] to_ascii(input logic [BCD_W-1:0] d);
    return ASCII_ZERO + {3'b000, d};
  endfunction

endpackage : trip_stats_pkg
`default_nettype wire

// File: rtl/trip_stats_bcd2_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : bcd2_counter                                                |
// | Brief  : Two-digit BCD counter 00..99. sat_mode=1 sticks at 99,      |
// |          sat_mode=0 wraps 99->00. clr has priority over inc.         |
// | Ports  : clk, reset (sync, active low), inc, clr, sat_mode,          |
// |          tens/ones (BCD digits)                                      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module bcd2_counter
  import trip_stats_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             sat_mode,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = '0;
      ones_d = '0;
    end else if (inc) begin
      if (ones_q != 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q != 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = '0;
      end else if (!sat_mode) begin
        tens_d = '0;
        ones_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule : bcd2_counter
`default_nettype wire

// File: rtl/trip_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : trip_stats                                                  |
// | Brief  : Bicycle trip computer. Synchronizes the wheel sensor and    |
// |          two buttons, runs an IDLE/RUN/PAUSED FSM, and keeps speed   |
// |          (pulses in the last second), distance and elapsed time as   |
// |          two-digit BCD values presented as ASCII characters.         |
// | Ports  : clk, reset (sync, active low)                               |
// |          wheel_pulse, start_stop, clear  - asynchronous levels       |
// |          speed/dist/time _tens/_ones     - ASCII digits (7 bit)      |
// |          update                          - digit-change strobe       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module trip_stats
  import trip_stats_pkg::*;
#(
  parameter int CLK_HZ          = 100000000,
  parameter int PULSES_PER_UNIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wheel_pulse,
  input  logic       start_stop,
  input  logic       clear,
  output logic [6:0] speed_tens,
  output logic [6:0] speed_ones,
  output logic [6:0] dist_tens,
  output logic [6:0] dist_ones,
  output logic [6:0] time_tens,
  output logic [6:0] time_ones,
  output logic       update
);

  localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam int SUB_W = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(PULSES_PER_UNIT - 1);

  // ------------------------------------------------------------------
  // Input synchronizers and rising-edge detectors.
  // Bit order: [0] wheel_pulse, [1] start_stop, [2] clear.
  // sync3 holds the previous synchronized level; the detected edge is
  // registered so it appears three cycles after the pin rises.
  // ------------------------------------------------------------------
  logic [2:0] w_pins;
  logic [2:0] sync1_q, sync2_q, sync3_q, edge_q;
  logic [1:0] arm_q;
  logic       w_armed;

  assign w_pins  = {clear, start_stop, wheel_pulse};
  // The edge detector stays blind until the pipeline holds real pin
  // samples, so a pin already high at reset release gives no edge.
  assign w_armed = (arm_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
      arm_q   <= '0;
    end else begin
      sync1_q <= w_pins;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= w_armed ? (sync2_q & ~sync3_q) : 3'b000;
      arm_q   <= w_armed ? arm_q : arm_q + 2'd1;
    end
  end

  logic w_pulse_e, w_ss_e, w_clr_e;
  assign w_pulse_e = edge_q[0];
  assign w_ss_e    = edge_q[1];
  assign w_clr_e   = edge_q[2];

  // ------------------------------------------------------------------
  // Run-control FSM. Clear beats start_stop when both arrive together.
  // ------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       w_run;

  assign w_run = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    if (w_clr_e) begin
      state_d = ST_IDLE;
    end else if (w_ss_e) begin
      case (state_q)
        ST_IDLE:   state_d = ST_RUN;
        ST_RUN:    state_d = ST_PAUSED;
        ST_PAUSED: state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // One-second prescaler: zero in IDLE, frozen in PAUSED so a partial
  // second resumes where it left off.
  // ------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               w_tick;
  logic               w_tick_eff;
  logic               w_pause_entry;
  logic               w_cnt_pulse;

  assign w_tick        = w_run && (presc_q == PRESC_MAX);
  assign w_tick_eff    = w_tick && !w_clr_e;
  assign w_pause_entry = w_run && w_ss_e && !w_clr_e;
  assign w_cnt_pulse   = w_run && w_pulse_e && !w_clr_e;

  always_comb begin
    presc_d = presc_q;
    if (w_clr_e || (state_q == ST_IDLE)) begin
      presc_d = '0;
    end else if (w_run) begin
      presc_d = w_tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Pulses-per-unit sub-counter; its wrap advances distance.
  // ------------------------------------------------------------------
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             w_unit;

  assign w_unit = w_cnt_pulse && (sub_q == SUB_MAX);

  always_comb begin
    sub_d = sub_q;
    if (w_clr_e) begin
      sub_d = '0;
    end else if (w_cnt_pulse) begin
      sub_d = (sub_q == SUB_MAX) ? '0 : sub_q + SUB_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // BCD counters: elapsed time (wraps), distance and speed window
  // (both saturate). The window empties on every tick and on pause.
  // ------------------------------------------------------------------
  bcd2_t w_time, w_dist, w_win;

  bcd2_counter u_time (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_tick_eff),
    .clr      (w_clr_e),
    .sat_mode (1'b0),
    .tens     (w_time.tens),
    .ones     (w_time.ones)
  );

  bcd2_counter u_dist (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_unit),
    .clr      (w_clr_e),
    .sat_mode (1'b1),
    .tens     (w_dist.tens),
    .ones     (w_dist.ones)
  );

  bcd2_counter u_win (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_cnt_pulse),
    .clr      (w_clr_e || w_tick_eff || w_pause_entry),
    .sat_mode (1'b1),
    .tens     (w_win.tens),
    .ones     (w_win.ones)
  );

  // Displayed speed: loads the window on tick, counting a pulse that
  // lands in the tick cycle itself. Entering PAUSED blanks it to 00.
  bcd2_t speed_q, speed_d;

  always_comb begin
    speed_d = speed_q;
    if (w_clr_e || w_pause_entry) begin
      speed_d = BCD2_ZERO;
    end else if (w_tick_eff) begin
      speed_d = w_cnt_pulse ? bcd2_inc_sat(w_win) : w_win;
    end
  end

  // ------------------------------------------------------------------
  // Change detect: snapshot of last cycle's digits; update is high in
  // the cycle right after any displayed digit changed.
  // ------------------------------------------------------------------
  logic [6*BCD_W-1:0] w_digits;
  logic [6*BCD_W-1:0] snap_q;

  assign w_digits = {w_time, w_dist, speed_q};
  assign update   = (w_digits != snap_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      sub_q   <= '0;
      speed_q <= BCD2_ZERO;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sub_q   <= sub_d;
      speed_q <= speed_d;
      snap_q  <= w_digits;
    end
  end

  assign speed_tens = to_ascii(speed_q.tens);
  assign speed_ones = to_ascii(speed_q.ones);
  assign dist_tens  = to_ascii(w_dist.tens);
  assign dist_ones  = to_ascii(w_dist.ones);
  assign time_tens  = to_ascii(w_time.tens);
  assign time_ones  = to_ascii(w_time.ones);

endmodule : trip_stats
`default_nettype wire

// File: tb/tb_trip_stats.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_trip_stats                                               |
// | Brief  : Scoreboard bench for trip_stats. The driver feeds pin       |
// |          rises into a trip-computer reference model; every change    |
// |          of displayed digits is queued and a monitor pops one entry  |
// |          per update strobe.                                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_trip_stats;

  localparam int CLK_HZ = 10;
  localparam int PPU    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wheel_pulse, start_stop, clear;
  logic [6:0] speed_tens, speed_ones, dist_tens, dist_ones, time_tens, time_ones;
  logic       update;

  always #5 clk = ~clk;

  trip_stats #(.CLK_HZ(CLK_HZ), .PULSES_PER_UNIT(PPU)) dut (
    .clk         (clk),
    .reset       (reset),
    .wheel_pulse (wheel_pulse),
    .start_stop  (start_stop),
    .clear       (clear),
    .speed_tens  (speed_tens),
    .speed_ones  (speed_ones),
    .dist_tens   (dist_tens),
    .dist_ones   (dist_ones),
    .time_tens   (time_tens),
    .time_ones   (time_ones),
    .update      (update)
  );

  int checks = 0;
  int errors = 0;
  int n_upd  = 0;

  logic [41:0] exp_q[$];

  function automatic logic [6:0] asc(input int v);
    return 7'(48 + v);
  endfunction

  function automatic logic [41:0] pack(input int t, input int d, input int s);
    return {asc(t / 10), asc(t % 10), asc(d / 10), asc(d % 10), asc(s / 10), asc(s % 10)};
  endfunction

  function automatic int sat99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  logic [41:0] w_act;
  assign w_act = {time_tens, time_ones, dist_tens, dist_ones, speed_tens, speed_ones};

  // ---------------- reference model (trip-computer rules) -------------
  // mode: 0 idle, 1 running, 2 paused
  int m_mode, m_phase, m_sub, m_dist, m_time, m_speed, m_win;
  int l_time, l_dist, l_speed;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_sub = 0;
    m_dist = 0; m_time = 0; m_speed = 0; m_win = 0;
    l_time = 0; l_dist = 0; l_speed = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [2:0] ev);
    bit running, second_done, counted;
    if (ev[2]) begin
      m_mode = 0; m_phase = 0; m_sub = 0;
      m_dist = 0; m_time = 0; m_speed = 0; m_win = 0;
    end else begin
      running     = (m_mode == 1);
      second_done = running && (m_phase == CLK_HZ - 1);
      counted     = running && ev[0];
      if (counted) begin
        m_sub++;
        if (m_sub == PPU) begin
          m_sub  = 0;
          m_dist = sat99(m_dist + 1);
        end
      end
      if (second_done) begin
        m_time  = (m_time + 1) % 100;
        m_speed = sat99(m_win + (counted ? 1 : 0));
        m_win   = 0;
      end else if (counted) begin
        m_win = sat99(m_win + 1);
      end
      if (m_mode == 0) m_phase = 0;
      else if (running) m_phase = (m_phase + 1) % CLK_HZ;
      if (ev[1]) begin
        if (m_mode == 1) begin
          m_mode = 2; m_speed = 0; m_win = 0;
        end else begin
          m_mode = 1;
        end
      end
    end
    if (m_time != l_time || m_dist != l_dist || m_speed != l_speed) begin
      exp_q.push_back(pack(m_time, m_dist, m_speed));
      l_time = m_time; l_dist = m_dist; l_speed = m_speed;
    end
  endtask

  // ---------------- monitor ------------------------------------------
  always @(negedge clk) begin
    if (update === 1'b1) begin
      logic [41:0] e;
      n_upd++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL update_unexpected: got digits %h, none expected", w_act);
      end else begin
        e = exp_q.pop_front();
        if (w_act !== e) begin
          errors++;
          $display("FAIL update_digits: got %h expected %h", w_act, e);
        end
      end
    end
  end

  // ---------------- driver -------------------------------------------
  // Pin rises reach the counters four clock edges after being driven.
  logic [2:0] dly [4];

  task automatic cyc(input bit rn, input bit p, input bit s, input bit c);
    logic [2:0] r;
    @(posedge clk);
    if (!reset) begin
      model_reset();
      for (int i = 0; i < 4; i++) dly[i] = 3'b000;
    end else begin
      model_step(dly[3]);
    end
    dly[3] = dly[2]; dly[2] = dly[1]; dly[1] = dly[0]; dly[0] = 3'b000;
    #1;
    r = {c & ~clear, s & ~start_stop, p & ~wheel_pulse};
    reset = rn; wheel_pulse = p; start_stop = s; clear = c;
    if (rn) dly[0] = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Random activity; each pin is forced low between highs.
  task automatic rnd(input int n, input int sdiv, input int cdiv);
    bit p, s, c;
    for (int i = 0; i < n; i++) begin
      p = !wheel_pulse && ($urandom_range(0, 2) == 0);
      s = (sdiv > 0) && !start_stop && ($urandom_range(0, sdiv - 1) == 0);
      c = (cdiv > 0) && !clear && ($urandom_range(0, cdiv - 1) == 0);
      cyc(1'b1, p, s, c);
    end
  endtask

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0;
    reset = 1'b0; wheel_pulse = 1'b0; start_stop = 1'b0; clear = 1'b0;
    for (int i = 0; i < 4; i++) dly[i] = 3'b000;
    model_reset();

    // S1: reset
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("s1_digits", w_act, pack(0, 0, 0));
    check_int("s1_update", int'(update), 0);
    check_int("s1_no_updates", n_upd, 0);

    // S2: start and let three seconds pass
    u0 = n_upd;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    idle(36);
    check("s2_time3", w_act, pack(3, 0, 0));
    check_int("s2_update_count", n_upd - u0, 3);

    // S3: five pulses inside one second (max rate is one per 2 cycles)
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    check("s3_cleared", w_act, pack(0, 0, 0));
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 25; i++) begin
      cyc(1'b1, (i % 2 == 1) && (i <= 9), 1'b0, 1'b0);
      if (i == 15) check("s3_speed5", w_act, pack(1, 2, 5));
    end
    check("s3_speed0", w_act, pack(2, 2, 0));

    // S4: 250 pulses saturate distance; 100 ticks wrap time
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 1005; i++) begin
      cyc(1'b1, (i % 2 == 1) && (i <= 499), 1'b0, 1'b0);
      if (i == 1000) check("s4_sat99", w_act, pack(99, 99, 0));
    end
    check("s4_time_wrap", w_act, pack(0, 99, 0));

    // S5: pause after 5 ticks, hold 40 cycles, resume
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(6);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 95; i++) begin
      if (i == 62) u0 = n_upd;
      cyc(1'b1, (i % 2 == 1) && (i != 55), (i == 55), 1'b0);
    end
    check("s5_paused", w_act, pack(5, 13, 0));
    check_int("s5_pause_quiet", n_upd - u0, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rnd(40, 0, 0);

    // S6: clear and start_stop together while running
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(6);
    check("s6_cleared", w_act, pack(0, 0, 0));
    u0 = n_upd;
    rnd(30, 0, 0);
    check("s6_idle_hold", w_act, pack(0, 0, 0));
    check_int("s6_idle_quiet", n_upd - u0, 0);

    // Random activity, a mid-run reset, more random activity
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rnd(700, 40, 200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("reset_midrun", w_act, pack(0, 0, 0));
    check_int("reset_update", int'(update), 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    rnd(800, 40, 250);

    idle(20);
    check_int("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trip_stats
`default_nettype wire

// File: doc/trip_stats.md
TRIP_STATS -- requirements
Module: trip_stats

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clock cycles per one-second tick (benches override to 10).
REQ-002 Parameter PULSES_PER_UNIT, default 20, wheel pulses per distance unit; legal range 1..1023.
REQ-003 clk  input  1  system clock, same clock as the VGA pipeline; the block has one clock.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge only.
REQ-005 wheel_pulse  input  1  raw wheel-sensor level, asynchronous; one rising edge per revolution.
REQ-006 start_stop  input  1  debounced button level; each rising edge toggles run/pause.
REQ-007 clear  input  1  debounced button level; each rising edge returns the trip to zero.
REQ-008 speed_tens, speed_ones  output  7 each  ASCII digits of pulses in last completed second.
REQ-009 dist_tens, dist_ones  output  7 each  ASCII digits of distance units travelled.
REQ-010 time_tens, time_ones  output  7 each  ASCII digits of elapsed running seconds.
REQ-011 update  output  1  one-cycle strobe, high in the cycle after any digit output changes.

Function
REQ-012 Every digit output SHALL equal 7'h30 plus a registered BCD digit 0..9; no other codes are permitted.
REQ-013 wheel_pulse, start_stop and clear SHALL each pass a 2-flop synchronizer, then a rising-edge detector; an edge is one cycle wide and appears 3 cycles after the pin rises.
REQ-014 FSM states: IDLE, RUN, PAUSED; IDLE->RUN, RUN->PAUSED and PAUSED->RUN occur on a start_stop edge.
REQ-015 A clear edge SHALL force IDLE from any state and zero all counters next cycle; when clear and start_stop edges coincide, clear wins and start_stop is dropped.
REQ-016 Prescaler counts 0..CLK_HZ-1 only in RUN; tick is high for the cycle in which it equals CLK_HZ-1, after which it wraps to 0.
REQ-017 In IDLE the prescaler is held at 0; in PAUSED it holds its value, so the partial second resumes on return to RUN.
REQ-018 Time SHALL increment by 1 on each tick; 99 wraps to 00.
REQ-019 In RUN, each pulse edge SHALL advance a sub-counter 0..PULSES_PER_UNIT-1; on wrap, distance increments by 1 and saturates at 99; the sub-counter keeps cycling at saturation.
REQ-020 In RUN, pulse edges SHALL accumulate in a BCD speed window saturating at 99.
REQ-021 On tick, the speed outputs SHALL load the window value, and the window resets to 0.
REQ-022 A pulse edge in the tick cycle SHALL be included in the loaded speed value, saturating at 99.
REQ-023 Pulse edges in IDLE or PAUSED SHALL be ignored.
REQ-024 On entry to PAUSED, the speed outputs and window SHALL clear to 00; distance and time hold.
REQ-025 Digit outputs SHALL change only on the clk edge following the causing event: one cycle after the detected edge, or after the tick.

Reset
REQ-026 While reset is low at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL become 7'h30.
REQ-027 Under the same condition, update SHALL go to 0, and the prescaler, sub-counter, window and synchronizer/edge flops SHALL go to 0.
REQ-028 A reset mid-count SHALL discard all accumulated state; no edge is detected from a pin that is already high when reset releases.

Structure
REQ-029 A shared package/include file SHALL hold the FSM state encodings (2 bits), the ASCII_ZERO constant 7'h30 and the BCD digit width.
REQ-030 Sub-module bcd2_counter: two-digit BCD counter with inputs inc, clr and sat_mode (saturate at 99 vs wrap), and outputs tens/ones.
REQ-031 bcd2_counter SHALL be instantiated three times: time (wrap), distance (saturate) and speed window (saturate).

Verification (CLK_HZ=10, PULSES_PER_UNIT=2)
REQ-032 Scenario 1: reset low 2 cycles, then release -> all six digits 7'h30, update 0, FSM IDLE.
REQ-033 Scenario 2: start_stop edge, wait 30 cycles -> time_tens/ones = 7'h30/7'h33, three update pulses.
REQ-034 Scenario 3: in RUN, 7 pulses within one second -> at the tick, speed = 7'h30/7'h37 and distance = 7'h30/7'h33; the next second with no pulses gives speed 00.
REQ-035 Scenario 4: 250 pulses in RUN -> distance saturates at 7'h39/7'h39; time runs 99 -> 00 when driven through 100 ticks.
REQ-036 Scenario 5: pause after 5 ticks, hold 40 cycles, resume -> time stays 05 during the pause and speed shows 00.
REQ-037 Scenario 6: clear and start_stop edges in the same cycle during RUN -> FSM IDLE, all digits 00, no further counting.
